// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared constants and FSM state type for the shift-and-add multiplier controller.
package shift_add_mult_ctrl_pkg;

    localparam int unsigned MULT_WIDTH = 4;
    localparam int unsigned PROD_W     = 2 * MULT_WIDTH;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Operand/result bundle between the board-level operand source and the multiplier.
interface shift_add_mult_ctrl_if
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) ();

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );

endinterface

// File: rtl/ripple_adder8.sv
// Fixed 8-bit ripple-carry adder shared by the multiplier datapath.
module ripple_adder8 (
    input  logic [7:0] x_i,
    input  logic [7:0] y_i,
    input  logic       ci_i,
    output logic [7:0] sum_o,
    output logic       co_o
);

    logic carry;

    always_comb begin
        carry = ci_i;
        sum_o = '0;
        for (int i = 0; i < 8; i++) begin
            sum_o[i] = x_i[i] ^ y_i[i] ^ carry;
            carry    = (x_i[i] & y_i[i]) | (carry & (x_i[i] ^ y_i[i]));
        end
        co_o = carry;
    end

endmodule

// File: rtl/shift_add_mult_ctrl_datapath.sv
// Operand latches, accumulator and step counter; one partial-product add per step.
module shift_add_mult_ctrl_datapath
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 bit_o,
    output logic                 last_o,
    output logic [2*WIDTH-1:0]   sum_o
);

    localparam int unsigned ProdW = 2 * WIDTH;
    localparam int unsigned CntW  = $clog2(WIDTH);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [ProdW-1:0] acc_q;
    logic [ProdW-1:0] addend;
    logic [CntW-1:0]  cnt_q;
    // Carry-out cannot be set for legal operands; left unobserved on purpose.
    logic             co_unused;

    assign bit_o  = b_q[cnt_q];
    assign last_o = (cnt_q == CntW'(WIDTH - 1));
    assign addend = bit_o ? (ProdW'(a_q) << cnt_q) : '0;

    ripple_adder8 u_adder (
        .x_i   (acc_q),
        .y_i   (addend),
        .ci_i  (1'b0),
        .sum_o (sum_o),
        .co_o  (co_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (step_i) begin
            acc_q <= sum_o;
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned multiplier: IDLE/RUN/DONE control around the shift-and-add datapath.
module shift_add_mult_ctrl
    import shift_add_mult_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_add_mult_ctrl_if.slave  bus
);

    localparam int unsigned ProdW = 2 * WIDTH;

    state_e           state_q;
    state_e           state_d;
    logic             load;
    logic             step;
    logic             mul_bit;
    logic             last;
    logic [ProdW-1:0] sum;
    logic [ProdW-1:0] product_q;

    shift_add_mult_ctrl_datapath #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .step_i (step),
        .a_i    (bus.a),
        .b_i    (bus.b),
        .bit_o  (mul_bit),
        .last_o (last),
        .sum_o  (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            product_q <= '0;
        end else begin
            state_q <= state_d;
            if (step && last) begin
                product_q <= sum;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                step = 1'b1;
                if (last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The multiplier bit only steers the addend inside the datapath.
    logic unused_bit;
    assign unused_bit = mul_bit;

    // Outputs come straight from registered state: no path from start.
    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = (state_q == StDone);
    assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl with a cycle-level behavioural reference.
module tb_shift_add_mult_ctrl;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    shift_add_mult_ctrl_if #(.WIDTH(W)) bus ();

    shift_add_mult_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: an accepted op keeps busy for W+1 cycles, the last being done.
    int m_left;
    int m_pend;
    int m_prod;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_prod = 0;
        end else if (m_left == 0) begin
            if (bus.start === 1'b1) begin
                m_pend = int'(bus.a) * int'(bus.b);
                m_left = W + 1;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 1) m_prod = m_pend;
        end
    end

    always @(negedge clk) begin
        check("busy", int'(bus.busy), (m_left > 0) ? 1 : 0);
        check("done", int'(bus.done), (m_left == 1) ? 1 : 0);
        check("product", int'(bus.product), m_prod);
        if (!rst) check("carry_out", int'(dut.u_dp.co_unused), 0);
    end

    // Start at a negedge, release after one cycle, wait for done.
    task automatic run_op(input int av, input int bv, output int lat, output int busy_n);
        bus.a     = 4'(av);
        bus.b     = 4'(bv);
        bus.start = 1'b1;
        lat       = 0;
        busy_n    = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            lat++;
            if (bus.busy) busy_n++;
        end while (!bus.done && lat < 20);
        if (lat >= 20) check("done_timeout", lat, W + 1);
        @(negedge clk);
    endtask

    int lat;
    int bn;
    int dones;
    int last_t;
    int nth;

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_product", int'(bus.product), 0);
        rst = 1'b0;

        // Basic multiply, literal expectations.
        run_op(13, 11, lat, bn);
        check("basic_latency", lat, 5);
        check("basic_busy_cycles", bn, 5);
        check("basic_product", int'(bus.product), 8'h8F);

        run_op(15, 15, lat, bn);
        check("max_product", int'(bus.product), 8'hE1);
        run_op(0, 9, lat, bn);
        check("zero_a_product", int'(bus.product), 0);
        run_op(7, 0, lat, bn);
        check("zero_b_product", int'(bus.product), 0);

        // Start pulses during RUN and DONE are ignored.
        bus.a = 4'd3; bus.b = 4'd5; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); bus.a = 4'd15; bus.b = 4'd15; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_start_done", int'(bus.done), 1);
        check("busy_start_product", int'(bus.product), 15);
        bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("busy_start_extra_done", dones, 0);
        check("busy_start_hold", int'(bus.product), 15);

        // Reset on the second RUN cycle discards the operation.
        bus.a = 4'd9; bus.b = 4'd9; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_product", int'(bus.product), 0);
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("midrst_no_done", dones, 0);
        run_op(2, 3, lat, bn);
        check("after_rst_product", int'(bus.product), 6);

        // Back-to-back with start held high; operands change every cycle.
        last_t = -1;
        nth    = 0;
        for (int i = 0; i < 36; i++) begin
            bus.a     = 4'((i * 5 + 3) & 15);
            bus.b     = 4'((i * 7 + 1) & 15);
            bus.start = 1'b1;
            @(negedge clk);
            if (bus.done) begin
                if (nth == 0) check("b2b_first_time", i + 1, 5);
                if (nth == 0) check("b2b_first_product", int'(bus.product), 3);
                if (nth == 1) check("b2b_second_product", int'(bus.product), 11);
                if (last_t >= 0) check("b2b_period", i + 1 - last_t, 6);
                last_t = i + 1;
                nth++;
            end
        end
        check("b2b_done_count", nth, 6);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        // Exhaustive sweep.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run_op(x, y, lat, bn);
                check("sweep_product", int'(bus.product), x * y);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_add_mult_ctrl.md
Name: shift_add_mult_ctrl

Overview:
Sequential 4x4 unsigned multiplier controller using shift-and-add. It time-multiplexes the team's 8-bit ripple-carry adder, running one partial-product add per clock. Operands are latched on a start handshake. The product is held until the next operation completes. It sits between the board-level operand inputs (switches/registers) and the display/output stage of the FPGA multiplier.

Parameters:
WIDTH, 4, operand width in bits. The product and the accumulator are 2*WIDTH bits. Only 4 is supported on target because the adder is a fixed 8 bits.

Ports:
clk    input   1        single system clock, all state on rising edge
rst    input   1        synchronous, active-high reset
start  input   1        request new multiply; sampled only in IDLE
a      input   WIDTH    multiplicand, latched when start accepted
b      input   WIDTH    multiplier, latched when start accepted
busy   output  1        high in RUN and DONE; start ignored while high
done   output  1        one-cycle pulse: product valid and newly updated
product output 2*WIDTH  result register; holds last result until next done

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free; state is registered.
- Reset (rst=1 at a clock edge, in any state, including mid-RUN):
  - state returns to IDLE;
  - busy=0, done=0, product=0;
  - internal a_reg, b_reg, acc and cnt are cleared to 0;
  - an in-flight operation is discarded and never produces a done.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: a_reg<=a, b_reg<=b, acc<=0, cnt<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - Each edge: if b_reg[cnt]=1, acc <= acc + (a_reg zero-extended to 2*WIDTH, shifted left by cnt). Otherwise acc is unchanged.
  - cnt increments on each RUN edge.
  - On the edge where cnt==WIDTH-1: product <= final sum (same value written to acc), go to DONE.
  - The addition uses the 8-bit ripple adder with carry-in 0. Its carry-out must be 0 for every legal operand pair (max 15*15=225). A nonzero carry-out is a design error and is flagged by a bench assertion; RTL ignores it.
- DONE:
  - busy=1, done=1 for exactly this one cycle.
  - Next edge: go to IDLE. start is ignored in DONE.
- Latency: start accepted at edge E0. RUN occupies edges E1..E4. done is high during the cycle after E4, i.e. WIDTH+1 cycles after E0.
- Throughput: one operation per WIDTH+2 cycles when start is held continuously high; a re-accept happens in IDLE.
- Operand changes while busy have no effect; the latched copies are used.
- product changes only at the RUN->DONE transition or on reset. It is stable in all other cycles.
- done and busy are registered, i.e. derived from state with no combinational path from start.

Decomposition:
- Shared package/header holds: state encodings (IDLE/RUN/DONE); WIDTH default; PROD_W = 2*WIDTH.
- One sub-module is natural: mult_datapath. It contains a_reg, b_reg, acc, cnt, the addend shifter and one instance of the team's 8-bit ripple-carry adder. It exposes the current multiplier bit and last-step flag to the FSM.
- The FSM stays in shift_add_mult_ctrl.

Test Plan:
- Basic multiply:
  - Stimulus: reset 2 cycles, then a=13, b=11, start pulse 1 cycle.
  - Required: done pulses exactly 5 cycles after the accepting edge; product=8'h8F (143); busy high for 5 cycles (4 RUN + 1 DONE).
- Max operands and zero:
  - Stimulus: a=15, b=15, then a=0, b=9, then a=7, b=0.
  - Required: products 8'hE1, 8'h00, 8'h00; adder carry-out is never 1 (assertion).
- Start while busy:
  - Stimulus: start a=3, b=5; pulse start with a=15, b=15 during RUN and again during DONE.
  - Required: single done with product=15; no extra operation; product stays 15 afterward.
- Reset mid-operation:
  - Stimulus: start a=9, b=9; assert rst on the 2nd RUN cycle.
  - Required: next cycle busy=0, done=0, product=0; no done ever appears for that operation. A subsequent start with a=2, b=3 gives product=6.
- Back-to-back with start held high:
  - Stimulus: hold start=1 while a/b step through pairs.
  - Required: done every 6 cycles. Each product matches the a, b sampled at that accept edge. product is stable between done pulses.
- Exhaustive sweep:
  - Stimulus: all 256 (a,b) pairs, handshaked.
  - Required: product==a*b for every pair, scoreboarded against a reference model.
